// File: rtl/uart_rx_deserializer_pkg.sv
// Shared types and helpers for the UART receive deserializer.
// The optional parity check is enabled by defining PARITY_CHECK_EN.
package uart_rx_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic EVEN_PAR = 1'b0;
    localparam logic ODD_PAR  = 1'b1;

    // Two-out-of-three vote used to reject single-sample line noise.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Serial-in / parallel-out bundle of the UART receiver.
// The slave modport is the receiver; the master modport is the line driver / consumer.
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  par_err;
    logic                  stop_err;

    modport master (
        output RX_IN,
        output PAR_TYP,
        input  P_DATA,
        input  Data_Valid,
        input  par_err,
        input  stop_err
    );

    modport slave (
        input  RX_IN,
        input  PAR_TYP,
        output P_DATA,
        output Data_Valid,
        output par_err,
        output stop_err
    );
endinterface

// File: rtl/uart_rx_data_sampler.sv
// Bit-period timing and 3-point oversampling for the UART receiver.
// edge_cnt runs 0..PRESCALE-1 while enabled; bit_tick marks the last edge of a bit,
// at which point sampled_bit holds the majority vote of the three mid-bit samples.
module uart_rx_data_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE = 8,
    parameter int CNT_W    = $clog2(PRESCALE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    input  logic             enable,
    output logic             sampled_bit,
    output logic             bit_tick,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int  S0        = PRESCALE / 2 - 1;
    localparam int  S1        = PRESCALE / 2;
    localparam int  S2        = PRESCALE / 2 + 1;
    // With PRESCALE=4 the third sample coincides with the bit's last edge, so the vote
    // must use the live line value instead of the not-yet-captured sample.
    localparam bit  LAST_LIVE = (S2 == PRESCALE - 1);

    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [2:0]       samp_q, samp_d;

    // Advance the edge counter and capture the three mid-bit samples.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        samp_d     = samp_q;
        if (enable) begin
            if (edge_cnt_q == CNT_W'(PRESCALE - 1)) begin
                edge_cnt_d = '0;
            end else begin
                edge_cnt_d = edge_cnt_q + CNT_W'(1);
            end
            if (edge_cnt_q == CNT_W'(S0)) begin
                samp_d[0] = rx_in;
            end else if (edge_cnt_q == CNT_W'(S1)) begin
                samp_d[1] = rx_in;
            end else if (edge_cnt_q == CNT_W'(S2)) begin
                samp_d[2] = rx_in;
            end else begin
                samp_d = samp_q;
            end
        end else begin
            edge_cnt_d = '0;
            samp_d     = samp_q;
        end
    end

    // Register the counter and sample history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
            samp_q     <= 3'b111;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            samp_q     <= samp_d;
        end
    end

    assign sampled_bit = majority3(samp_q[0], samp_q[1], LAST_LIVE ? rx_in : samp_q[2]);
    assign bit_tick    = enable && (edge_cnt_q == CNT_W'(PRESCALE - 1));
    assign edge_cnt    = edge_cnt_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: start detect, LSB-first data recovery, optional parity,
// one stop bit, one-cycle result strobes. Define PARITY_CHECK_EN to include the parity bit.
module uart_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    uart_rx_deserializer_if.slave  rx_if
);

    localparam int CNT_W  = $clog2(PRESCALE);
    localparam int BCNT_W = $clog2(DATA_WIDTH);

    rx_state_e             state_q, state_d;
    logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  par_ok_s;
    logic                  sampled_bit_s;
    logic                  bit_tick_s;
    logic [CNT_W-1:0]      edge_cnt_s;
    logic                  sampler_en_s;

`ifdef PARITY_CHECK_EN
    logic par_bit_q, par_bit_d;
    logic par_typ_q, par_typ_d;

    // True when the received parity bit matches the data under the selected parity type.
    function automatic logic parity_ok(input logic [DATA_WIDTH-1:0] data,
                                       input logic par_bit, input logic par_typ);
        return ((^data) ^ (par_typ == ODD_PAR)) == par_bit;
    endfunction
`endif

    // The sampler runs for the whole frame and also in the IDLE cycle that sees the start edge,
    // so that cycle counts as edge 0 of the start bit.
    assign sampler_en_s = (state_q != IDLE) || !rx_if.RX_IN;

    uart_rx_data_sampler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_sampler (
        .clk         (CLK),
        .rst         (RST),
        .rx_in       (rx_if.RX_IN),
        .enable      (sampler_en_s),
        .sampled_bit (sampled_bit_s),
        .bit_tick    (bit_tick_s),
        .edge_cnt    (edge_cnt_s)
    );

    // Frame FSM next-state, data assembly and result strobes.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        p_data_d  = p_data_q;
        dv_d      = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;
        par_ok_s  = 1'b1;
`ifdef PARITY_CHECK_EN
        par_bit_d = par_bit_q;
        par_typ_d = par_typ_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_if.RX_IN) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_tick_s) begin
                    if (sampled_bit_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_tick_s) begin
                    shift_d = {sampled_bit_s, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == BCNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
`ifdef PARITY_CHECK_EN
                if (bit_tick_s) begin
                    par_bit_d = sampled_bit_s;
                    state_d   = STOP;
                end else begin
                    state_d = PARITY;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
`ifdef PARITY_CHECK_EN
                if (edge_cnt_s == '0) begin
                    par_typ_d = rx_if.PAR_TYP;
                end else begin
                    par_typ_d = par_typ_q;
                end
                par_ok_s = parity_ok(shift_q, par_bit_q, par_typ_q);
`endif
                if (bit_tick_s) begin
                    if (sampled_bit_s && par_ok_s) begin
                        p_data_d = shift_q;
                        dv_d     = 1'b1;
                    end else begin
                        serr_d = !sampled_bit_s;
                        perr_d = !par_ok_s;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_bit_q <= 1'b0;
            par_typ_q <= EVEN_PAR;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            p_data_q  <= p_data_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
`ifdef PARITY_CHECK_EN
            par_bit_q <= par_bit_d;
            par_typ_q <= par_typ_d;
`endif
        end
    end

    assign rx_if.P_DATA     = p_data_q;
    assign rx_if.Data_Valid = dv_q;
    assign rx_if.par_err    = perr_q;
    assign rx_if.stop_err   = serr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer (PRESCALE=8, DATA_WIDTH=8).
// Works with and without PARITY_CHECK_EN defined.
module tb_uart_rx_deserializer;

    localparam int DW = 8;
    localparam int P  = 8;
`ifdef PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_BITS = DW + 2 + int'(PAR_EN);
    localparam int LAT        = FRAME_BITS * P;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_flip;
        logic       ptyp;
        logic       exp_valid;
        logic       exp_perr;
        logic       exp_serr;
    } vec_t;

    typedef struct {
        logic [7:0] pdata;
        logic       valid;
        logic       perr;
        logic       serr;
        int         t_start;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [7:0] model_pdata = 8'h00;
    exp_t sb_q[$];
    vec_t vecs[$];

    uart_rx_deserializer_if #(.DATA_WIDTH(DW)) rif();

    uart_rx_deserializer #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .rx_if (rif)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every strobe cycle must match the oldest pending frame result.
    always @(negedge CLK) begin
        if (!RST && (rif.Data_Valid || rif.par_err || rif.stop_err)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: dv=%0b perr=%0b serr=%0b, expected none (cycle %0d)",
                         rif.Data_Valid, rif.par_err, rif.stop_err, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("data_valid", int'(rif.Data_Valid), int'(e.valid));
                check("par_err",    int'(rif.par_err),    int'(e.perr));
                check("stop_err",   int'(rif.stop_err),   int'(e.serr));
                check("p_data",     int'(rif.P_DATA),     int'(e.pdata));
                check("latency",    cyc - e.t_start,      LAT);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            rif.RX_IN = 1'b1;
        end
    endtask

    task automatic wait_empty(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge CLK);
            #1;
            if (sb_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: %0d expected strobe(s) never seen, expected 0 pending", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Drives one full frame; pushes the expected result when the start edge is driven.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip,
                              input logic ptyp, input int spike,
                              input logic exp_valid, input logic exp_perr, input logic exp_serr);
        logic [15:0] fb;
        exp_t e;
        fb = 16'hFFFF;
        fb[0] = 1'b0;
        for (int i = 0; i < DW; i++) fb[1+i] = data[i];
        fb[DW+1] = (^data) ^ ptyp ^ par_flip;
        fb[FRAME_BITS-1] = stop_bit;
        e.valid = exp_valid;
        e.perr  = exp_perr;
        e.serr  = exp_serr;
        e.pdata = exp_valid ? data : model_pdata;
        model_pdata = e.pdata;
        for (int c = 0; c < LAT; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                e.t_start = cyc;
                sb_q.push_back(e);
            end
            rif.PAR_TYP = ptyp;
            rif.RX_IN   = fb[c/P] ^ (c == spike);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rif.RX_IN   = 1'b1;
        rif.PAR_TYP = 1'b0;

        // Vector table: data, stop, parity flip, parity type, expected valid/perr/serr.
        vecs.push_back('{8'hBB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'hBB, 1'b1, 1'b1, 1'b0, !PAR_EN, PAR_EN, 1'b0});
        vecs.push_back('{8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, PAR_EN, 1'b1});
        vecs.push_back('{8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h6E, 1'b1, 1'b1, 1'b1, !PAR_EN, PAR_EN, 1'b0});

        repeat (4) @(negedge CLK);
        check("reset_p_data",     int'(rif.P_DATA),     0);
        check("reset_data_valid", int'(rif.Data_Valid), 0);
        check("reset_errs",       int'({rif.par_err, rif.stop_err}), 0);
        RST = 1'b0;
        idle(10);

        for (int i = 0; i < vecs.size(); i++) begin
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].par_flip, vecs[i].ptyp, -1,
                       vecs[i].exp_valid, vecs[i].exp_perr, vecs[i].exp_serr);
            idle(5);
            wait_empty("vector_strobe");
            check("vector_p_data_hold", int'(rif.P_DATA), int'(model_pdata));
        end

        // Short low glitch on the idle line must not produce a frame.
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            rif.RX_IN = 1'b0;
        end
        idle(30);
        check("glitch_p_data", int'(rif.P_DATA), int'(model_pdata));

        // Single-cycle spike at sample edge 4 of data bit 3 is voted out.
        send_frame(8'h08, 1'b1, 1'b0, 1'b0, 4*P + 4, 1'b1, 1'b0, 1'b0);
        idle(5);
        wait_empty("spike_strobe");

        // Back-to-back frames with no idle gap.
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b0, 1'b0);
        idle(5);
        wait_empty("b2b_strobe");
        check("b2b_p_data", int'(rif.P_DATA), 8'hF0);

        // Reset 40 cycles into a frame aborts it at once.
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            rif.RX_IN = (c < P) ? 1'b0 : 1'b1;
        end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("midreset_p_data",     int'(rif.P_DATA),     0);
        check("midreset_data_valid", int'(rif.Data_Valid), 0);
        check("midreset_errs",       int'({rif.par_err, rif.stop_err}), 0);
        model_pdata = 8'h00;
        idle(3);
        RST = 1'b0;
        idle(5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b0, 1'b0);
        idle(5);
        wait_empty("after_reset_strobe");
        check("after_reset_p_data", int'(rif.P_DATA), 8'hA5);

        idle(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
